// File: rtl/lfsr_decrypt_if.sv
// Data-memory port bundle between the LFSR decryptor (master) and dat_mem (slave).
// The read is combinational: data_out follows raddr in the same cycle.
interface lfsr_decrypt_if;
  logic [7:0] raddr;
  logic [7:0] data_out;
  logic [7:0] waddr;
  logic [7:0] data_in;
  logic       write_en;

  modport master (
    output raddr,
    output waddr,
    output data_in,
    output write_en,
    input  data_out
  );

  modport slave (
    input  raddr,
    input  waddr,
    input  data_in,
    input  write_en,
    output data_out
  );
endinterface

// File: rtl/lfsr_decrypt.sv
// LFSR stream decryptor. Recovers the 6-bit keystream start state from the known
// preamble character, finds the feedback taps by trial against the preamble bytes,
// then decodes the ciphertext image and writes the plaintext (preamble stripped)
// back into data memory. Runs once after each init and then holds done.
module lfsr_decrypt #(
  parameter logic [7:0] ENC_BASE = 8'd64,
  parameter logic [7:0] ENC_LEN  = 8'd64,
  parameter logic [7:0] MSG_BASE = 8'd0,
  parameter logic [7:0] PRE_CHAR = 8'h5F,
  parameter logic [7:0] PROBE    = 8'd6
) (
  input  logic                 clk,
  input  logic                 init,
  lfsr_decrypt_if.master       mem,
  output logic                 done,
  output logic                 err,
  output logic [5:0]           found_taps,
  output logic [7:0]           msg_len
);

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_TLOAD  = 3'd1,
    S_TRY    = 3'd2,
    S_DLOAD  = 3'd3,
    S_DECODE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // One keystream step: shift left, feedback is the parity of the tapped bits.
  function automatic logic [5:0] lfsr_step(input logic [5:0] s, input logic [5:0] t);
    lfsr_step = {s[4:0], ^(s & t)};
  endfunction

  // Candidate feedback patterns, tried in index order.
  function automatic logic [5:0] cand_taps(input logic [2:0] idx);
    case (idx)
      3'd0:    cand_taps = 6'h21;
      3'd1:    cand_taps = 6'h2D;
      3'd2:    cand_taps = 6'h30;
      3'd3:    cand_taps = 6'h33;
      3'd4:    cand_taps = 6'h36;
      3'd5:    cand_taps = 6'h39;
      default: cand_taps = 6'h21;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  start_q, start_d;
  logic [5:0]  lfsr_q, lfsr_d;
  logic [5:0]  taps_q, taps_d;
  logic [2:0]  i_q, i_d;
  logic [7:0]  k_q, k_d;
  logic [7:0]  j_q, j_d;
  logic        skip_q, skip_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [5:0]  found_q, found_d;
  logic [7:0]  msg_len_q, msg_len_d;

  logic [7:0]  raddr_s;
  logic [7:0]  waddr_s;
  logic [7:0]  data_in_s;
  logic        we_s;
  logic [5:0]  nxt_s;
  logic [7:0]  plain_s;
  logic [7:0]  j_next_s;

  // State register; init clears everything and restarts the run on release.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q   <= S_START;
      start_q   <= 6'd0;
      lfsr_q    <= 6'd0;
      taps_q    <= 6'd0;
      i_q       <= 3'd0;
      k_q       <= 8'd0;
      j_q       <= 8'd0;
      skip_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      found_q   <= 6'd0;
      msg_len_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      lfsr_q    <= lfsr_d;
      taps_q    <= taps_d;
      i_q       <= i_d;
      k_q       <= k_d;
      j_q       <= j_d;
      skip_q    <= skip_d;
      done_q    <= done_d;
      err_q     <= err_d;
      found_q   <= found_d;
      msg_len_q <= msg_len_d;
    end
  end

  // Next-state logic and memory port drive for the search/decode sequence.
  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    lfsr_d    = lfsr_q;
    taps_d    = taps_q;
    i_d       = i_q;
    k_d       = k_q;
    j_d       = j_q;
    skip_d    = skip_q;
    done_d    = done_q;
    err_d     = err_q;
    found_d   = found_q;
    msg_len_d = msg_len_q;
    raddr_s   = 8'd0;
    waddr_s   = 8'd0;
    data_in_s = 8'd0;
    we_s      = 1'b0;
    nxt_s     = lfsr_step(lfsr_q, taps_q);
    plain_s   = mem.data_out ^ {2'b00, lfsr_q};
    j_next_s  = j_q;

    case (state_q)
      S_START: begin
        // Byte 0 is preamble, so its low six bits reveal the start state.
        raddr_s = ENC_BASE;
        start_d = mem.data_out[5:0] ^ PRE_CHAR[5:0];
        i_d     = 3'd0;
        state_d = S_TLOAD;
      end
      S_TLOAD: begin
        lfsr_d  = start_q;
        taps_d  = cand_taps(i_q);
        k_d     = 8'd1;
        state_d = S_TRY;
      end
      S_TRY: begin
        raddr_s = ENC_BASE + k_q;
        // Whole-byte compare: the untouched top bits must match the preamble too.
        if (mem.data_out == (PRE_CHAR ^ {2'b00, nxt_s})) begin
          lfsr_d = nxt_s;
          if (k_q == PROBE) begin
            found_d = taps_q;
            state_d = S_DLOAD;
          end else begin
            k_d = k_q + 8'd1;
          end
        end else begin
          if (i_q == 3'd5) begin
            err_d     = 1'b1;
            done_d    = 1'b1;
            msg_len_d = 8'd0;
            state_d   = S_DONE;
          end else begin
            i_d     = i_q + 3'd1;
            state_d = S_TLOAD;
          end
        end
      end
      S_DLOAD: begin
        // taps_q still holds the winning candidate.
        lfsr_d  = start_q;
        k_d     = 8'd0;
        j_d     = 8'd0;
        skip_d  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        raddr_s = ENC_BASE + k_q;
        lfsr_d  = nxt_s;
        if (skip_q && (plain_s == PRE_CHAR)) begin
          // Still inside the leading preamble run: absorb without writing.
          j_next_s = j_q;
        end else begin
          skip_d    = 1'b0;
          we_s      = 1'b1;
          waddr_s   = MSG_BASE + j_q;
          data_in_s = plain_s;
          j_next_s  = j_q + 8'd1;
        end
        j_d = j_next_s;
        if (k_q == (ENC_LEN - 8'd1)) begin
          done_d    = 1'b1;
          msg_len_d = j_next_s;
          state_d   = S_DONE;
        end else begin
          k_d = k_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_START;
      end
    endcase
  end

  // Memory port must be combinational (same-cycle read); hold it quiet during init.
  always_comb begin
    if (init) begin
      mem.raddr    = 8'd0;
      mem.waddr    = 8'd0;
      mem.data_in  = 8'd0;
      mem.write_en = 1'b0;
    end else begin
      mem.raddr    = raddr_s;
      mem.waddr    = waddr_s;
      mem.data_in  = data_in_s;
      mem.write_en = we_s;
    end
  end

  assign done       = done_q;
  assign err        = err_q;
  assign found_taps = found_q;
  assign msg_len    = msg_len_q;

endmodule
